// File: rtl/vedic_mult_seq_if.sv
// Handshake bundle for vedic_mult_seq: operand side (in_*), result side (out_*), and status.
// master = producer/consumer environment, slave = the multiplier.
interface vedic_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/vedic_mult_seq.sv
// Sequential Urdhva-Tiryagbhyam multiplier: WIDTH x WIDTH -> 2*WIDTH, two bits of b per cycle.
// Latency WIDTH/2 cycles after accept; result held in DONE until out_ready, no new accept until handoff.
module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  vedic_mult_seq_if.slave    s_if
);

  localparam int PW = 2 * WIDTH;
  localparam int ND = WIDTH / 2;
  localparam int KW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ND - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [WIDTH-1:0]    r_a_mag;
  logic [WIDTH-1:0]    r_b_mag;
  logic                r_neg;
  logic [PW-1:0]       r_acc;
  logic [KW-1:0]       r_k;
  logic [PW-1:0]       r_product;

  logic                w_accept;
  logic                w_last;
  logic [WIDTH-1:0]    w_a_mag_in;
  logic [WIDTH-1:0]    w_b_mag_in;
  logic                w_neg_in;
  logic [WIDTH-1:0]    w_b_shift;
  logic [1:0]          w_digit;
  logic [WIDTH-1:0]    w_pp0;
  logic [WIDTH-1:0]    w_pp1;
  logic [WIDTH-1:1]    w_c;
  logic [WIDTH+1:0]    w_row;
  logic [PW-1:0]       w_row_ext;
  logic [PW-1:0]       w_row_shl;
  logic [PW-1:0]       w_acc_next;
  logic [PW-1:0]       w_prod_next;

  assign w_accept = s_if.in_valid && (r_state == S_IDLE);
  assign w_last   = (r_k == K_LAST);

  // Most-negative operand maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign w_a_mag_in = (s_if.signed_mode && s_if.a[WIDTH-1]) ? (~s_if.a + WIDTH'(1)) : s_if.a;
  assign w_b_mag_in = (s_if.signed_mode && s_if.b[WIDTH-1]) ? (~s_if.b + WIDTH'(1)) : s_if.b;
  assign w_neg_in   = s_if.signed_mode && (s_if.a[WIDTH-1] ^ s_if.b[WIDTH-1]);

  assign w_b_shift = r_b_mag >> {r_k, 1'b0};
  assign w_digit   = w_b_shift[1:0];
  assign w_pp0     = r_a_mag & {WIDTH{w_digit[0]}};
  assign w_pp1     = r_a_mag & {WIDTH{w_digit[1]}};

  // WIDTH x 2 row: vertical term, then crosswise pairs via half adder and ripple full adders.
  assign w_row[0] = w_pp0[0];
  assign w_row[1] = w_pp0[1] ^ w_pp1[0];
  assign w_c[1]   = w_pp0[1] & w_pp1[0];

  for (genvar gi = 2; gi < WIDTH; gi++) begin : g_fa
    assign w_row[gi] = w_pp0[gi] ^ w_pp1[gi-1] ^ w_c[gi-1];
    assign w_c[gi]   = (w_pp0[gi] & w_pp1[gi-1]) |
                       (w_pp0[gi] & w_c[gi-1])   |
                       (w_pp1[gi-1] & w_c[gi-1]);
  end

  assign w_row[WIDTH]   = w_pp1[WIDTH-1] ^ w_c[WIDTH-1];
  assign w_row[WIDTH+1] = w_pp1[WIDTH-1] & w_c[WIDTH-1];

  assign w_row_ext   = {{(PW-WIDTH-2){1'b0}}, w_row};
  assign w_row_shl   = w_row_ext << {r_k, 1'b0};
  assign w_acc_next  = r_acc + w_row_shl;
  assign w_prod_next = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)           w_state_nxt = S_MUL;
      S_MUL:  if (w_last)             w_state_nxt = S_DONE;
      S_DONE: if (s_if.out_ready)     w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_k       <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_a_mag <= w_a_mag_in;
        r_b_mag <= w_b_mag_in;
        r_neg   <= w_neg_in;
        r_acc   <= '0;
        r_k     <= '0;
      end else if (r_state == S_MUL) begin
        r_acc <= w_acc_next;
        r_k   <= w_last ? '0 : r_k + KW'(1);
        if (w_last) begin
          r_product <= w_prod_next;
        end
      end
    end
  end

  assign s_if.in_ready  = (r_state == S_IDLE);
  assign s_if.busy      = (r_state != S_IDLE);
  assign s_if.out_valid = (r_state == S_DONE);
  assign s_if.product   = r_product;

endmodule

// File: doc/vedic_mult_seq.md
# vedic_mult_seq

Parametrised, sequential Urdhva-Tiryagbhyam multiplier that takes one WIDTH x WIDTH operand pair per transaction and returns a 2*WIDTH-bit product. It processes operand b two bits per cycle using a WIDTH x 2 Vedic partial-product row and accumulates the rows. It adds a signed/unsigned mode and valid/ready handshakes on both sides. It is the successor to the team's fixed 4x4 combinational Vedic multiplier, for datapaths that need wider operands at low area and can tolerate multi-cycle latency.

## Interface
- WIDTH, 8, operand width; must be even and >= 4; product width is 2*WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes product.
- product  out  2*WIDTH  result; held stable while out_valid=1.
- busy  out  1  high in MUL or DONE state.

## Operation
- States: IDLE, MUL, DONE. Reset enters IDLE.
- in_ready = (state==IDLE). busy = (state!=IDLE).
- Accept occurs on an edge where in_valid && in_ready. At accept:
  - a, b, and signed_mode are sampled; later changes on these inputs are ignored.
  - a_mag/b_mag = two's-complement magnitude when signed_mode=1 and the operand MSB=1, else the raw value. -2^(WIDTH-1) yields magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits.
  - neg = signed_mode & (a[MSB]^b[MSB]).
  - Accumulator (2*WIDTH bits) is cleared; digit counter k=0. Next state is MUL.
- MUL, one step per cycle, k = 0 .. WIDTH/2-1:
  - row = a_mag * b_mag[2k+1:2k], formed with Vedic 2-bit cross products: bitwise AND, half-adder, and ripple full-adder; width WIDTH+2.
  - acc += row << 2k, modulo 2^(2*WIDTH). The true magnitude product never overflows.
  - On the step with k = WIDTH/2-1, product is loaded with (neg ? -acc_final : acc_final) in 2*WIDTH-bit two's complement. Next state is DONE.
- DONE: out_valid=1. When out_ready=1 on an edge, out_valid clears and next state is IDLE.
- product keeps its last value after the handoff until the next completion overwrites it.
- Zero operands follow the normal path, with no early termination. A negative zero product is always 0.

## Timing
- Reset (asynchronous, at any point): state=IDLE, out_valid=0, product=0, accumulator=0, k=0. in_ready goes to 1 and busy to 0 immediately (combinational from state). An in-flight operation is discarded with no output.
- Latency: out_valid rises after the (WIDTH/2)th rising edge following the accept edge. For WIDTH=8: accept at edge 0, out_valid high after edge 4.
- Throughput: one result per WIDTH/2+2 cycles when out_ready is held at 1 and in_valid is continuous (accept, WIDTH/2 MUL cycles, DONE, IDLE).
- No overlap: in_ready stays 0 from the accept edge until the edge that completes the handoff. A same-edge handoff plus new accept is not supported.
- Backpressure: in DONE with out_ready=0, out_valid and product hold indefinitely.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Test plan
- WIDTH=8, unsigned, a=15, b=15, out_ready=1 -> product=225 (0x00E1), out_valid after exactly 4 edges past accept, pulse of one cycle.
- WIDTH=8, unsigned, a=255, b=255 -> 0xFE01. Signed: a=-128, b=-128 -> 0x4000. Signed: a=-3 (0xFD), b=5 -> 0xFFF1. Signed: a=-128, b=127 -> 0xC080.
- WIDTH=4 instance, exhaustive 256 pairs in both modes -> matches the reference model. Unsigned results equal the legacy 4x4 combinational multiplier output.
- Backpressure: complete 7*9, hold out_ready=0 for 10 cycles -> out_valid=1 and product=63 stable, in_ready=0. Raise out_ready -> one-cycle handoff, in_ready=1 the next cycle.
- Input churn: toggle a, b, and signed_mode every cycle during MUL -> result reflects only the values sampled at accept.
- Reset mid-operation: assert rst_n=0 asynchronously during the 2nd MUL cycle -> out_valid=0, product=0, in_ready=1 without waiting for a clock edge. A new transaction after release (6*7) -> 42 with nominal latency.
